// File: rtl/hdmi_cfg_pkg.sv
// Shared types for the HDMI transmitter I2C configuration sequencer:
// FSM state encoding, configuration table entry and default device address.
package hdmi_cfg_pkg;

    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h72;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_LOAD,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CHECK,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

endpackage

// File: rtl/hdmi_i2c_cfg_seq_if.sv
// Request/acknowledge bus between the configuration sequencer (master)
// and the byte-level I2C master engine (slave).
interface hdmi_i2c_cfg_seq_if;

    logic       i2c_write_req;
    logic       i2c_write_req_ack;
    logic       i2c_read_req;
    logic       i2c_read_req_ack;
    logic [7:0] i2c_slave_dev_addr;
    logic [7:0] i2c_slave_reg_addr;
    logic [7:0] i2c_write_data;
    logic [7:0] i2c_read_data;
    logic       error;

    modport master (
        output i2c_write_req, i2c_read_req, i2c_slave_dev_addr,
               i2c_slave_reg_addr, i2c_write_data,
        input  i2c_write_req_ack, i2c_read_req_ack, i2c_read_data, error
    );

    modport slave (
        input  i2c_write_req, i2c_read_req, i2c_slave_dev_addr,
               i2c_slave_reg_addr, i2c_write_data,
        output i2c_write_req_ack, i2c_read_req_ack, i2c_read_data, error
    );

endinterface

// File: rtl/hdmi_cfg_rom.sv
// Combinational HDMI transmitter register table: idx -> {reg_addr, data}.
// Indices at or beyond DEPTH (or past the built-in table) return {8'hFF, 8'hFF}.
module hdmi_cfg_rom
    import hdmi_cfg_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic [7:0] idx,
    output cfg_entry_t entry
);

    always_comb begin
        // NOTE: default assignment first so every path drives entry and no latch is inferred.
        entry = {8'hFF, 8'hFF};
        if (32'(idx) < DEPTH) begin
            case (idx)
                8'd0:    entry = {8'h41, 8'h10};
                8'd1:    entry = {8'h98, 8'h03};
                8'd2:    entry = {8'h9A, 8'hE0};
                8'd3:    entry = {8'h9C, 8'h30};
                8'd4:    entry = {8'h9D, 8'h61};
                8'd5:    entry = {8'hA2, 8'hA4};
                8'd6:    entry = {8'hA3, 8'hA4};
                8'd7:    entry = {8'hE0, 8'hD0};
                8'd8:    entry = {8'hF9, 8'h00};
                8'd9:    entry = {8'h15, 8'h00};
                8'd10:   entry = {8'h16, 8'h30};
                8'd11:   entry = {8'h17, 8'h02};
                8'd12:   entry = {8'h18, 8'h46};
                8'd13:   entry = {8'hAF, 8'h06};
                8'd14:   entry = {8'h40, 8'h80};
                8'd15:   entry = {8'h4C, 8'h04};
                8'd16:   entry = {8'h3B, 8'h0A};
                8'd17:   entry = {8'h55, 8'h12};
                8'd18:   entry = {8'h56, 8'h08};
                8'd19:   entry = {8'h96, 8'h20};
                8'd20:   entry = {8'hBA, 8'h60};
                8'd21:   entry = {8'hD6, 8'hC0};
                8'd22:   entry = {8'h0A, 8'h01};
                8'd23:   entry = {8'h01, 8'h00};
                8'd24:   entry = {8'h02, 8'h18};
                8'd25:   entry = {8'h03, 8'h00};
                8'd26:   entry = {8'h0C, 8'hBC};
                8'd27:   entry = {8'h94, 8'hC0};
                8'd28:   entry = {8'h97, 8'h00};
                8'd29:   entry = {8'h3C, 8'h10};
                8'd30:   entry = {8'h48, 8'h08};
                8'd31:   entry = {8'h4A, 8'h80};
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_i2c_cfg_seq.sv
// Walks the HDMI transmitter register table over an I2C master after a power-up delay,
// retrying NACKed entries. Define HDMI_CFG_READBACK_EN to verify each write by read-back.
module hdmi_i2c_cfg_seq
    import hdmi_cfg_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter int          CFG_DEPTH = 32,
    parameter logic [23:0] PWR_DLY   = 24'd1_000_000,
    parameter int          RETRY_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    hdmi_i2c_cfg_seq_if.master i2c,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_fail,
    output logic [7:0]        fail_index
);

    localparam logic [7:0] LAST_IDX  = 8'(CFG_DEPTH - 1);
    localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

`ifdef HDMI_CFG_READBACK_EN
    localparam state_t WR_OK_STATE = ST_RD_REQ;
`else
    localparam state_t WR_OK_STATE = ST_NEXT;
`endif

    state_t      state;
    logic [7:0]  idx;
    logic [7:0]  retry_cnt;
    logic [23:0] dly_cnt;
    logic [1:0]  gap_cnt;
    logic [7:0]  reg_addr_q;
    logic [7:0]  write_data_q;
    logic        write_req_q;
    logic        read_req_q;
    logic        start_ok;
    cfg_entry_t  rom_entry;

    hdmi_cfg_rom #(.DEPTH(CFG_DEPTH)) u_rom (
        .idx   (idx),
        .entry (rom_entry)
    );

    assign start_ok = start && (state inside {ST_IDLE, ST_DONE, ST_FAIL});

    // gap_cnt keeps both requests low for three cycles after every ack, so the
    // master is back in idle before the next request rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= 8'h00;
            retry_cnt    <= 8'h00;
            dly_cnt      <= 24'd0;
            gap_cnt      <= 2'd0;
            fail_index   <= 8'h00;
            reg_addr_q   <= 8'h00;
            write_data_q <= 8'h00;
            write_req_q  <= 1'b0;
            read_req_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state; the later gap_cnt load wins over this decrement.
            if (gap_cnt != 2'd0) gap_cnt <= gap_cnt - 2'd1;

            if (start_ok) begin
                state     <= ST_PWR_WAIT;
                idx       <= 8'h00;
                retry_cnt <= 8'h00;
                dly_cnt   <= 24'd0;
            end else begin
                case (state)
                    ST_PWR_WAIT: begin
                        if (dly_cnt + 24'd1 >= PWR_DLY) state <= ST_LOAD;
                        else                            dly_cnt <= dly_cnt + 24'd1;
                    end
                    ST_LOAD: begin
                        reg_addr_q   <= rom_entry.reg_addr;
                        write_data_q <= rom_entry.data;
                        state        <= ST_WR_REQ;
                    end
                    ST_WR_REQ: begin
                        if (gap_cnt == 2'd0 && !i2c.i2c_read_req_ack) begin
                            write_req_q <= 1'b1;
                            state       <= ST_WR_WAIT;
                        end
                    end
                    ST_WR_WAIT: begin
                        if (i2c.i2c_write_req_ack) begin
                            write_req_q <= 1'b0;
                            gap_cnt     <= 2'd2;
                            state       <= i2c.error ? ST_CHECK : WR_OK_STATE;
                        end
                    end
`ifdef HDMI_CFG_READBACK_EN
                    ST_RD_REQ: begin
                        if (gap_cnt == 2'd0 && !i2c.i2c_write_req_ack) begin
                            read_req_q <= 1'b1;
                            state      <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (i2c.i2c_read_req_ack) begin
                            read_req_q <= 1'b0;
                            gap_cnt    <= 2'd2;
                            state      <= (i2c.error || (i2c.i2c_read_data != write_data_q))
                                          ? ST_CHECK : ST_NEXT;
                        end
                    end
`endif
                    ST_CHECK: begin
                        if (retry_cnt < RETRY_LIM) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            state     <= ST_LOAD;
                        end else begin
                            fail_index <= idx;
                            state      <= ST_FAIL;
                        end
                    end
                    ST_NEXT: begin
                        retry_cnt <= 8'h00;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= ST_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy     = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});
    assign cfg_done = (state == ST_DONE);
    assign cfg_fail = (state == ST_FAIL);

    assign i2c.i2c_write_req      = write_req_q;
    assign i2c.i2c_slave_dev_addr = DEV_ADDR;
    assign i2c.i2c_slave_reg_addr = reg_addr_q;
    assign i2c.i2c_write_data     = write_data_q;

`ifdef HDMI_CFG_READBACK_EN
    assign i2c.i2c_read_req = read_req_q;
`else
    logic unused_rd;
    assign i2c.i2c_read_req = 1'b0;
    assign unused_rd        = ^{read_req_q, i2c.i2c_read_data};
`endif

endmodule

// File: tb/tb_hdmi_i2c_cfg_seq.sv
// Directed bench for hdmi_i2c_cfg_seq (CFG_DEPTH=4, PWR_DLY=10, RETRY_MAX=3) with a
// scripted I2C master model that acks two cycles after each request.
module tb_hdmi_i2c_cfg_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       cfg_done;
    logic       cfg_fail;
    logic [7:0] fail_index;

    hdmi_i2c_cfg_seq_if i2c ();

    hdmi_i2c_cfg_seq #(
        .DEV_ADDR  (8'h72),
        .CFG_DEPTH (4),
        .PWR_DLY   (24'd10),
        .RETRY_MAX (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .i2c        (i2c),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_fail   (cfg_fail),
        .fail_index (fail_index)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Master model controls and transaction log
    logic [7:0] nack_reg   = 8'h00;
    int         nack_left  = 0;
    logic       rb_bad_en  = 1'b0;
    logic [7:0] rb_bad_reg = 8'h00;
    int         wr_count   = 0;
    int         rd_count   = 0;
    logic [7:0] log_reg [0:63];
    logic [7:0] log_dat [0:63];
    int         m_cnt      = 0;
    int         viol       = 0;
    int         low_run    = 100;
    logic       prev_any   = 1'b0;

    logic [7:0] exp_reg [0:3];
    logic [7:0] exp_dat [0:3];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int count_reg(input logic [7:0] r);
        int n = 0;
        for (int i = 0; i < wr_count && i < 64; i++)
            if (log_reg[i] == r) n++;
        return n;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_log();
        wr_count = 0;
        rd_count = 0;
    endtask

    // I2C master model plus request-protocol monitor, all on the falling edge
    initial begin
        logic req_any;
        i2c.i2c_write_req_ack = 1'b0;
        i2c.i2c_read_req_ack  = 1'b0;
        i2c.i2c_read_data     = 8'h00;
        i2c.error             = 1'b0;
        forever begin
            @(negedge clk);
            i2c.i2c_write_req_ack = 1'b0;
            i2c.i2c_read_req_ack  = 1'b0;
            i2c.error             = 1'b0;
            req_any = i2c.i2c_write_req || i2c.i2c_read_req;
            if (i2c.i2c_write_req && i2c.i2c_read_req) viol++;
            if (req_any) begin
                if (!prev_any && low_run < 3) viol++;
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_any = req_any;
            if (req_any) begin
                m_cnt++;
                if (m_cnt == 2) begin
                    m_cnt = 0;
                    if (i2c.i2c_write_req) begin
                        i2c.i2c_write_req_ack = 1'b1;
                        if (wr_count < 64) begin
                            log_reg[wr_count] = i2c.i2c_slave_reg_addr;
                            log_dat[wr_count] = i2c.i2c_write_data;
                        end
                        wr_count++;
                        if (i2c.i2c_slave_reg_addr == nack_reg && nack_left > 0) begin
                            i2c.error = 1'b1;
                            nack_left--;
                        end
                    end else begin
                        i2c.i2c_read_req_ack = 1'b1;
                        rd_count++;
                        i2c.i2c_read_data = (rb_bad_en && i2c.i2c_slave_reg_addr == rb_bad_reg)
                                            ? 8'h00 : i2c.i2c_write_data;
                    end
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    initial begin
        int cyc;
        exp_reg = '{8'h41, 8'h98, 8'h9A, 8'h9C};
        exp_dat = '{8'h10, 8'h03, 8'hE0, 8'h30};
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy",       {31'd0, busy}, 32'd0);
        check("rst_cfg_done",   {31'd0, cfg_done}, 32'd0);
        check("rst_cfg_fail",   {31'd0, cfg_fail}, 32'd0);
        check("rst_wr_req",     {31'd0, i2c.i2c_write_req}, 32'd0);
        check("rst_rd_req",     {31'd0, i2c.i2c_read_req}, 32'd0);
        check("rst_fail_index", {24'd0, fail_index}, 32'h00);
        check("rst_reg_addr",   {24'd0, i2c.i2c_slave_reg_addr}, 32'h00);
        check("rst_write_data", {24'd0, i2c.i2c_write_data}, 32'h00);
        check("rst_dev_addr",   {24'd0, i2c.i2c_slave_dev_addr}, 32'h72);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal pass; first request 12 cycles after start with PWR_DLY=10
        clear_log();
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (i2c.i2c_write_req !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("first_req_latency", cyc, 12);
        check("first_reg_addr",   {24'd0, i2c.i2c_slave_reg_addr}, 32'h41);
        check("first_write_data", {24'd0, i2c.i2c_write_data}, 32'h10);
        wait_idle("nominal_idle", 500);
        check("nominal_wr_count", wr_count, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("nominal_reg%0d", i), {24'd0, log_reg[i]}, {24'd0, exp_reg[i]});
            check($sformatf("nominal_dat%0d", i), {24'd0, log_dat[i]}, {24'd0, exp_dat[i]});
        end
        check("nominal_cfg_done", {31'd0, cfg_done}, 32'd1);
        check("nominal_cfg_fail", {31'd0, cfg_fail}, 32'd0);
        check("nominal_busy",     {31'd0, busy}, 32'd0);
`ifdef HDMI_CFG_READBACK_EN
        check("nominal_rd_count", rd_count, 4);
`else
        check("nominal_rd_count", rd_count, 0);
`endif

        // Entry 2 NACKed twice, then acked
        clear_log();
        nack_reg  = 8'h9A;
        nack_left = 2;
        pulse_start();
        wait_idle("retry_idle", 800);
        check("retry_wr_count", wr_count, 6);
        check("retry_entry2_sends", count_reg(8'h9A), 3);
        check("retry_last_reg", {24'd0, log_reg[5]}, 32'h9C);
        check("retry_cfg_done", {31'd0, cfg_done}, 32'd1);
        check("retry_cfg_fail", {31'd0, cfg_fail}, 32'd0);

        // Entry 1 NACKed persistently
        clear_log();
        nack_reg  = 8'h98;
        nack_left = 1000;
        pulse_start();
        wait_idle("fail_idle", 800);
        check("fail_wr_count", wr_count, 5);
        check("fail_entry1_sends", count_reg(8'h98), 4);
        check("fail_cfg_fail", {31'd0, cfg_fail}, 32'd1);
        check("fail_cfg_done", {31'd0, cfg_done}, 32'd0);
        check("fail_index", {24'd0, fail_index}, 32'd1);
        repeat (60) @(negedge clk);
        check("fail_no_more_writes", wr_count, 5);
        check("fail_held", {31'd0, cfg_fail}, 32'd1);

        // start pulsed mid-pass is ignored
        clear_log();
        nack_left = 0;
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        check("midpass_busy", {31'd0, busy}, 32'd1);
        wait_idle("midpass_idle", 800);
        check("midpass_wr_count", wr_count, 4);
        check("midpass_cfg_done", {31'd0, cfg_done}, 32'd1);

`ifdef HDMI_CFG_READBACK_EN
        // Read-back of entry 0 returns 8'h00 instead of 8'h10
        clear_log();
        rb_bad_en  = 1'b1;
        rb_bad_reg = 8'h41;
        pulse_start();
        wait_idle("rb_idle", 800);
        check("rb_wr_count", wr_count, 4);
        check("rb_rd_count", rd_count, 4);
        check("rb_cfg_fail", {31'd0, cfg_fail}, 32'd1);
        check("rb_fail_index", {24'd0, fail_index}, 32'd0);
        rb_bad_en = 1'b0;
`endif

        // Reset asserted while a write request is outstanding
        clear_log();
        pulse_start();
        cyc = 0;
        while (i2c.i2c_write_req !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid_req_seen", {31'd0, i2c.i2c_write_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_req_async_drop", {31'd0, i2c.i2c_write_req}, 32'd0);
        check("rstmid_busy_async", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rstmid_no_resume_busy", {31'd0, busy}, 32'd0);
        check("rstmid_no_resume_req", {31'd0, i2c.i2c_write_req}, 32'd0);
        check("rstmid_cfg_done", {31'd0, cfg_done}, 32'd0);
        check("rstmid_wr_count", wr_count, 0);

        // Mutual exclusion and three-cycle request spacing over the whole run
        check("protocol_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_i2c_cfg_seq.md
HDMI_I2C_CFG_SEQ -- requirements
Module: hdmi_i2c_cfg_seq

Interface
REQ-001 Parameters SHALL be:
- DEV_ADDR, 8'h72, 8-bit HDMI transmitter I2C address, LSB ignored.
- CFG_DEPTH, 32, number of table entries, range 1..256.
- PWR_DLY, 24'd1_000_000, clk cycles to wait after start before the first access.
- RETRY_MAX, 3, retries per entry after the first attempt fails.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- start, in, 1, single-cycle pulse that begins a configuration pass.
- i2c_write_req, out, 1, write request to the I2C master.
- i2c_write_req_ack, in, 1, one-cycle completion strobe from the master.
- i2c_read_req, out, 1, read request to the I2C master.
- i2c_read_req_ack, in, 1, one-cycle completion strobe from the master.
- i2c_slave_dev_addr, out, 8, device address; always DEV_ADDR.
- i2c_slave_reg_addr, out, 8, register address of the current entry.
- i2c_write_data, out, 8, write data of the current entry.
- i2c_read_data, in, 8, readback byte.
- error, in, 1, NACK flag; valid in the ack cycle.
- busy, out, 1, a pass is in progress.
- cfg_done, out, 1, level; every entry was written successfully.
- cfg_fail, out, 1, level; an entry exhausted its retries.
- fail_index, out, 8, index of the failing entry.

Function
REQ-003 The FSM states SHALL be IDLE, PWR_WAIT, LOAD, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, NEXT, DONE, FAIL.

REQ-004 Entry into a pass:
- start in IDLE, DONE or FAIL SHALL go to PWR_WAIT.
- Entry clears idx, retry_cnt, cfg_done, cfg_fail and the delay counter.
- start in any other state SHALL be ignored.

REQ-005 PWR_WAIT SHALL count PWR_DLY cycles, then go to LOAD.
- PWR_DLY=0 SHALL go to LOAD on the next cycle.

REQ-006 LOAD SHALL register {reg, data} from the table at idx onto i2c_slave_reg_addr and i2c_write_data, then go to WR_REQ.
- Both outputs SHALL stay stable until the next LOAD.

REQ-007 WR_REQ SHALL drive i2c_write_req high, registered, and enter WR_WAIT.
- The request stays high until i2c_write_req_ack is sampled high.
- The request falls on the cycle after the ack.
- Requests SHALL never rise while the opposite ack is high.

REQ-008 In the write-ack cycle, error SHALL be sampled.
- error=1: attempt failed, go to CHECK.
- error=0: go to RD_REQ when HDMI_CFG_READBACK_EN is defined, otherwise to NEXT.

REQ-009 RD_REQ and RD_WAIT SHALL run the same handshake on i2c_read_req and i2c_read_req_ack.
- In the read-ack cycle, i2c_read_data SHALL be compared with the table data.
- A mismatch or error=1 counts as a failed attempt.

REQ-010 A failed attempt SHALL go to CHECK.
- retry_cnt < RETRY_MAX: increment retry_cnt, go to LOAD.
- Otherwise: set fail_index=idx, go to FAIL.

REQ-011 NEXT SHALL clear retry_cnt.
- idx = CFG_DEPTH-1: go to DONE.
- Otherwise: increment idx, go to LOAD.
- idx SHALL NOT wrap.

REQ-012 busy SHALL be 1 in every state except IDLE, DONE and FAIL.
- cfg_done=1 only in DONE; cfg_fail=1 only in FAIL.
- Both SHALL hold until the next accepted start.

REQ-013 i2c_read_req and i2c_write_req SHALL be mutually exclusive in every cycle.

REQ-014 Minimum spacing between two requests SHALL be 3 cycles.
- This guarantees the master has returned to idle before the next request.

Reset
REQ-015 With rst_n low, outputs SHALL be:
- State IDLE.
- Both requests 0; busy, cfg_done and cfg_fail 0.
- fail_index 8'h00; reg_addr and write_data 8'h00.
- i2c_slave_dev_addr = DEV_ADDR.

REQ-016 Deassertion mid-pass SHALL NOT resume the pass.
- The I2C master SHALL share the same reset, inverted.

Configuration
REQ-017 Macro HDMI_CFG_READBACK_EN controls readback.
- Defined: every write is followed by a read-back compare (REQ-009).
- Undefined: RD_REQ and RD_WAIT are absent, and i2c_read_req is tied to 0.

Structure
REQ-018 Package hdmi_cfg_pkg SHALL hold:
- The state enum.
- The cfg_entry_t struct {reg, data}.
- The default DEV_ADDR constant.

REQ-019 Sub-module hdmi_cfg_rom SHALL be a combinational lookup: idx[7:0] -> cfg_entry_t.
- Out-of-range idx SHALL return {8'hFF, 8'hFF}.

Verification
REQ-020 The bench SHALL cover:
- Nominal pass, CFG_DEPTH=4, always-ack model -> 4 writes with the table reg/data, cfg_done=1, busy=0.
- NACK on entry 2 twice, then ack, RETRY_MAX=3 -> entry 2 sent 3 times, cfg_done=1.
- Persistent NACK on entry 1 -> 4 attempts, cfg_fail=1, fail_index=1, no further requests.
- READBACK_EN with the model returning 8'h00 where 8'h10 is expected -> retries, then cfg_fail=1.
- start pulsed mid-pass -> ignored; rst_n low during WR_WAIT -> request drops asynchronously, IDLE after release.
- PWR_DLY=10 -> first i2c_write_req exactly 12 cycles after start.
